// File: rtl/fp32_pkg.sv
// fp32_pkg: shared FP32 field widths, special encodings and FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp32_pkg;

  localparam int WORD_W   = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int SIG_W    = 24;   // mantissa with hidden bit
  localparam int ACC_W    = 48;   // full 24x24 product
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fp32_seq_multiplier_if.sv
// fp32_seq_multiplier_if: request/result bundle for the iterative FP32 multiplier.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the engine is idle.
//   master: drives start, multiplicand, multiplier; sees busy, valid, out_reg, flags
//   slave : the multiplier engine
interface fp32_seq_multiplier_if;
  import fp32_pkg::*;

  logic              start;
  logic [WORD_W-1:0] multiplicand;
  logic [WORD_W-1:0] multiplier;
  logic              busy;
  logic              valid;
  logic [WORD_W-1:0] out_reg;
  logic [1:0]        flags;    // {overflow, underflow}

  modport master (
    output start, multiplicand, multiplier,
    input  busy, valid, out_reg, flags
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, valid, out_reg, flags
  );

endinterface

// File: rtl/fp32_classify.sv
// fp32_classify: flags an FP32 operand as zero, infinity or NaN (exp=0 counts as zero).
// Latency: combinational.
// Backpressure: none.
//   exp, man : exponent and mantissa fields of the operand
//   is_zero, is_inf, is_nan : classification outputs, mutually exclusive
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-1:0] man,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);

  logic exp_all_ones;

  assign exp_all_ones = (exp == {EXP_W{1'b1}});
  // Denormals are flushed: any zero exponent is a zero regardless of mantissa.
  assign is_zero = (exp == '0);
  assign is_inf  = exp_all_ones && (man == '0);
  assign is_nan  = exp_all_ones && (man != '0);

endmodule

// File: rtl/fp32_seq_multiplier.sv
// fp32_seq_multiplier: iterative FP32 multiplier, one shift-add mantissa step per clock.
// Latency: valid 26 edges after the accepted start (1 edge for special operands).
// Backpressure: none; start is ignored while busy or finishing, nothing is queued.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of fp32_seq_multiplier_if (start/operands in, busy/valid/out_reg/flags out)
// Build option FP_MUL_RNE_EN: round-to-nearest-even in NORM; otherwise truncate.
module fp32_seq_multiplier
  import fp32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  fp32_seq_multiplier_if.slave  bus
);

  localparam logic signed [9:0] BIAS_S = 10'(EXP_BIAS);
  localparam logic signed [9:0] MAX_S  = 10'(EXP_MAX);
  localparam logic [4:0]        LAST_I = 5'(ITER - 1);

  state_t state_q, state_d;

  logic [SIG_W-1:0] ma_q, mb_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic             sign_q;
  logic [ACC_W-1:0] acc_q;
  logic [4:0]       iter_q;
  logic [WIDTH-1:0] res_q;        // result waiting for the DONE edge
  logic [1:0]       res_flags_q;
  logic [WIDTH-1:0] out_q;
  logic [1:0]       flags_q;
  logic             valid_q;
  logic             busy_q;

  // ---------------------------------------------------------------- classify
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic special;
  logic sign_in;
  logic [WIDTH-1:0] special_res;

  fp32_classify u_cls_a (
    .exp     (bus.multiplicand[30:23]),
    .man     (bus.multiplicand[22:0]),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan)
  );

  fp32_classify u_cls_b (
    .exp     (bus.multiplier[30:23]),
    .man     (bus.multiplier[22:0]),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan)
  );

  assign sign_in = bus.multiplicand[31] ^ bus.multiplier[31];
  assign special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

  // Priority: NaN and inf*0 first, then infinity, then zero.
  always_comb begin
    special_res = {sign_in, {(WIDTH-1){1'b0}}};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      special_res = QNAN;
    else if (a_inf || b_inf)
      special_res = {sign_in, POS_INF[30:0]};
  end

  // ---------------------------------------------------------------- normalise
  logic signed [9:0] exp_sum, exp_fin;
  logic [MAN_W-1:0]  man_fin;
  logic [WIDTH-1:0]  norm_res;
  logic [1:0]        norm_flags;
`ifdef FP_MUL_RNE_EN
  logic              guard, sticky, round_up;
  logic [SIG_W-1:0]  man_rnd;
`endif

  always_comb begin
    exp_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS_S;
    exp_fin = exp_sum;
    man_fin = acc_q[45:23];
`ifdef FP_MUL_RNE_EN
    guard   = acc_q[22];
    sticky  = |acc_q[21:0];
`endif
    // Product of two [1,2) significands lies in [1,4): bit 47 marks the upper half.
    if (acc_q[47]) begin
      exp_fin = exp_sum + 10'sd1;
      man_fin = acc_q[46:24];
`ifdef FP_MUL_RNE_EN
      guard   = acc_q[23];
      sticky  = |acc_q[22:0];
`endif
    end
`ifdef FP_MUL_RNE_EN
    round_up = guard & (sticky | man_fin[0]);
    man_rnd  = {1'b0, man_fin} + {{(SIG_W-1){1'b0}}, round_up};
    man_fin  = man_rnd[MAN_W-1:0];
    // Carry out of the mantissa means 1.111.. rounded to 10.000..; the
    // mantissa field is already zero, only the exponent moves.
    if (man_rnd[SIG_W-1])
      exp_fin = exp_fin + 10'sd1;
`endif
    norm_flags = 2'b00;
    norm_res   = {sign_q, exp_fin[7:0], man_fin};
    if (exp_fin >= MAX_S) begin
      norm_res   = {sign_q, POS_INF[30:0]};
      norm_flags = 2'b10;
    end else if (exp_fin <= 10'sd0) begin
      norm_res   = {sign_q, {(WIDTH-1){1'b0}}};
      norm_flags = 2'b01;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = special ? DONE : MUL;
      MUL:  if (iter_q == LAST_I) state_d = NORM;
      NORM: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_q        <= '0;
      mb_q        <= '0;
      ea_q        <= '0;
      eb_q        <= '0;
      sign_q      <= 1'b0;
      acc_q       <= '0;
      iter_q      <= '0;
      res_q       <= '0;
      res_flags_q <= '0;
      out_q       <= '0;
      flags_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q      <= 1'b1;
            sign_q      <= sign_in;
            ma_q        <= {1'b1, bus.multiplicand[22:0]};
            mb_q        <= {1'b1, bus.multiplier[22:0]};
            ea_q        <= bus.multiplicand[30:23];
            eb_q        <= bus.multiplier[30:23];
            acc_q       <= '0;
            iter_q      <= '0;
            // Preloaded for the special path; overwritten by NORM otherwise.
            res_q       <= special_res;
            res_flags_q <= 2'b00;
          end
        end
        MUL: begin
          if (mb_q[iter_q])
            acc_q <= acc_q + ({{(ACC_W-SIG_W){1'b0}}, ma_q} << iter_q);
          iter_q <= iter_q + 5'd1;
        end
        NORM: begin
          res_q       <= norm_res;
          res_flags_q <= norm_flags;
        end
        DONE: begin
          out_q   <= res_q;
          flags_q <= res_flags_q;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.out_reg = out_q;
  assign bus.flags   = flags_q;

endmodule

// File: tb/tb_fp32_seq_multiplier.sv
// tb_fp32_seq_multiplier: directed and random checks of fp32_seq_multiplier
// against an arithmetic reference model (product by plain multiplication).
module tb_fp32_seq_multiplier;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fp32_seq_multiplier_if bus ();

  fp32_seq_multiplier #(.WIDTH(32), .ITER(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {flags, result}.
  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s, az, ai, an, bz, bi, bn;
    int          e, sh;
    logic [47:0] p, q, rem, half;
    s  = a[31] ^ b[31];
    az = (a[30:23] == 8'd0);
    bz = (b[30:23] == 8'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (an || bn || (ai && bz) || (az && bi)) return {2'b00, 32'h7FC00000};
    if (ai || bi) return {2'b00, s, 8'hFF, 23'd0};
    if (az || bz) return {2'b00, s, 31'd0};
    p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = p[47] ? 24 : 23;
    if (p[47]) e++;
    q   = p >> sh;
    rem = p - (q << sh);
`ifdef FP_MUL_RNE_EN
    half = 48'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && q[0])) q++;
    if (q == 48'h100_0000) begin
      q = q >> 1;
      e++;
    end
`else
    half = rem;  // truncation discards the remainder
`endif
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], q[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'd0) || (a[30:23] == 8'hFF) ||
        (b[30:23] == 8'd0) || (b[30:23] == 8'hFF)) return 1;
    return 26;
  endfunction

  // Waits (bounded) for valid after start was accepted at E0; lat = edges after E0.
  task automatic wait_valid(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 1;  // busy sampled just after E0 is counted by the caller's check
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.valid) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [1:0] fl,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    wait_valid(lat, busy_cnt);
    res = bus.out_reg;
    fl  = bus.flags;
    chk("busy_low_at_valid", bus.busy, 1'b0);
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res;
    logic [1:0]  fl;
    logic [33:0] exp;
    int          lat, bc;
    exp = ref_mul(a, b);
    run_op(a, b, res, fl, lat, bc);
    chk({tag, "_res"},   res, exp[31:0]);
    chk({tag, "_flags"}, fl,  exp[33:32]);
    chk({tag, "_lat"},   lat, ref_lat(a, b));
    chk({tag, "_busy"},  bc,  ref_lat(a, b));
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int          c;
    r = $urandom();
    c = $urandom_range(0, 9);
    case (c)
      0: r[30:23] = 8'd0;
      1: r[30:23] = 8'hFF;
      2: r[30:0]  = 31'h7F80_0000;
      3, 4: r[30:23] = 8'($urandom_range(1, 254));
      default: r[30:23] = 8'($urandom_range(64, 190));
    endcase
    return r;
  endfunction

  initial begin
    int          lat, bc, seen;
    logic [31:0] res;
    logic [1:0]  fl;

    n_checks = 0;
    n_fail   = 0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  bus.busy,    1'b0);
    chk("rst_valid", bus.valid,   1'b0);
    chk("rst_out",   bus.out_reg, 32'd0);
    chk("rst_flags", bus.flags,   2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    check_op("2x3", 32'h40000000, 32'h40400000);
    chk("2x3_abs", bus.out_reg, 32'h40C00000);
    @(posedge clk); #1;
    chk("valid_one_cycle", bus.valid, 1'b0);
    chk("out_held", bus.out_reg, 32'h40C00000);
    check_op("1p5sq", 32'h3FC00000, 32'h3FC00000);
    chk("1p5sq_abs", bus.out_reg, 32'h40100000);
    check_op("ovf", 32'h7F000000, 32'h7F000000);
    chk("ovf_abs", {bus.flags, bus.out_reg}, {2'b10, 32'h7F800000});
    check_op("unf", 32'h00800000, 32'h00800000);
    chk("unf_abs", {bus.flags, bus.out_reg}, {2'b01, 32'h00000000});
    check_op("inf_x_0", 32'h7F800000, 32'h00000000);
    chk("inf_x_0_abs", bus.out_reg, 32'h7FC00000);
    check_op("neg_x_0", 32'hC0000000, 32'h00000000);
    chk("neg_x_0_abs", bus.out_reg, 32'h80000000);
    check_op("ninf_x_2", 32'hFF800000, 32'h40000000);
    chk("ninf_x_2_abs", bus.out_reg, 32'hFF800000);
    check_op("round", 32'h3F800001, 32'h3FC00000);
`ifdef FP_MUL_RNE_EN
    chk("round_abs", bus.out_reg, 32'h3FC00002);
`else
    chk("round_abs", bus.out_reg, 32'h3FC00001);
`endif
    check_op("nan_in", 32'h7FC12345, 32'h3F800000);
    check_op("rne_carry", 32'h3FFFFFFF, 32'h3F800001);

    // Start while busy: second start at E5 must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'h40000000; bus.multiplier = 32'h40400000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'h3FC00000; bus.multiplier = 32'h3FC00000;
    @(posedge clk); #1;  // E5
    bus.start = 1'b0;
    wait_valid(lat, bc);
    chk("ignore_lat", lat + 5, 26);
    chk("ignore_res", bus.out_reg, 32'h40C00000);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.valid) seen++;
    end
    chk("ignore_no_second", seen, 0);

    // Reset mid-operation at E10.
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'h3FC00000; bus.multiplier = 32'h3FC00000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy",  bus.busy,    1'b0);
    chk("midrst_valid", bus.valid,   1'b0);
    chk("midrst_out",   bus.out_reg, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    check_op("after_rst", 32'h40000000, 32'h40400000);
    chk("after_rst_abs", bus.out_reg, 32'h40C00000);

    // Random back-to-back operations.
    for (int n = 0; n < 150; n++) begin
      check_op("rand", rand_op(), rand_op());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
